// File: rtl/psk_frame_pkg.sv
// Shared definitions for the PSK transmit framer: FSM states, default
// preamble and the m_tuser modulation-select encoding.
package psk_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    SEQ  = 2'd2,
    PAY  = 2'd3
  } state_t;

  typedef logic [1:0] dibit_t;

  // Barker-13 preamble, sent MSB first
  localparam int unsigned   DEF_PRE_LEN     = 13;
  localparam logic [12:0]   DEF_PRE_PATTERN = 13'b1111100110101;

  // m_tuser selects the modulator constellation
  localparam logic TUSER_BPSK = 1'b1;
  localparam logic TUSER_QPSK = 1'b0;

  // A BPSK bit is carried on both symbol lanes
  function automatic dibit_t bpsk_sym(input logic b);
    return {b, b};
  endfunction

endpackage

// File: rtl/psk_dibit_ser.sv
// One-byte payload buffer that hands the byte to the modulator as four
// dibits, MSB pair first. Remembers whether the byte closed the packet.
module psk_dibit_ser
  import psk_frame_pkg::*;
(
  input  logic       clk_16M384,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] byte_in,
  input  logic       last_in,
  output logic       empty,
  output logic       last_dibit,
  output logic       last_byte,
  output dibit_t     dibit
);

  logic [7:0] byte_q;
  logic       full_q;
  logic       last_q;
  logic [1:0] idx_q;

  assign empty      = !full_q;
  assign last_dibit = full_q && (idx_q == 2'd3);
  assign last_byte  = last_q;

  // Buffer fill/drain; a load on the final dibit's handshake refills in place
  always_ff @(posedge clk_16M384 or negedge rst_n) begin
    if (!rst_n) begin
      byte_q <= '0;
      full_q <= 1'b0;
      last_q <= 1'b0;
      idx_q  <= '0;
    end else if (load) begin
      byte_q <= byte_in;
      full_q <= 1'b1;
      last_q <= last_in;
      idx_q  <= '0;
    end else if (advance && full_q) begin
      if (idx_q == 2'd3) begin
        full_q <= 1'b0;
      end
      idx_q <= idx_q + 2'd1;
    end
  end

  // Select the dibit currently offered to the modulator
  always_comb begin
    dibit = '0;
    case (idx_q)
      2'd0:    dibit = byte_q[7:6];
      2'd1:    dibit = byte_q[5:4];
      2'd2:    dibit = byte_q[3:2];
      default: dibit = byte_q[1:0];
    endcase
  end

endmodule

// File: rtl/psk_framer.sv
// Transmit framer: BPSK preamble, BPSK sequence-number header, then the
// host payload as QPSK dibits, one symbol per modulator tready pulse.
module psk_framer
  import psk_frame_pkg::*;
#(
  parameter  int unsigned           BYTES       = 1,
  parameter  int unsigned           PRE_LEN     = DEF_PRE_LEN,
  parameter  logic [PRE_LEN-1:0]    PRE_PATTERN = DEF_PRE_PATTERN,
  parameter  int unsigned           SEQ_BITS    = 8,
  localparam int unsigned           BITS        = BYTES * 8
) (
  input  logic                clk_16M384,
  input  logic                rstn_16M384,
  input  logic [7:0]          s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  output logic [BITS-1:0]     m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                m_tuser,
  output logic                frame_busy,
  output logic                underrun,
  output logic [SEQ_BITS-1:0] frame_seq
);

  localparam int unsigned IDX_MAX = (PRE_LEN > SEQ_BITS) ? PRE_LEN : SEQ_BITS;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX + 1);

  logic [1:0]          rst_sync;
  logic                rst_n;
  state_t              state;
  logic                mv_q;
  logic                mu_q;
  dibit_t              sym_q;
  logic [IDX_W-1:0]    sym_idx;
  logic [IDX_W-1:0]    idx_dec;
  logic [PRE_LEN-1:0]  pre_shift;
  logic [SEQ_BITS-1:0] seq_shift;
  logic                pre_nxt;
  logic                seq_nxt;
  logic                in_pay;
  logic                hs;
  logic                ser_load;
  logic                ser_adv;
  logic                ser_empty;
  logic                ser_last_dibit;
  logic                ser_last_byte;
  dibit_t              ser_dibit;
  dibit_t              sym_out;

  // Reset asserts immediately, releases after two clock edges
  always_ff @(posedge clk_16M384 or negedge rstn_16M384) begin
    if (!rstn_16M384) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_n = rst_sync[1];

  // Header symbols come from registers; payload symbols straight from the buffer
  assign in_pay   = (state == PAY);
  assign m_tvalid = in_pay ? !ser_empty : mv_q;
  assign sym_out  = in_pay ? ser_dibit : sym_q;
  assign m_tdata  = {{(BITS-2){1'b0}}, sym_out};
  assign m_tuser  = in_pay ? TUSER_QPSK : mu_q;
  assign m_tlast  = in_pay && ser_last_dibit && ser_last_byte;
  assign hs       = m_tvalid && m_tready;

  // Accept a byte into an empty buffer, or as the last dibit of a non-final byte leaves
  assign s_tready = in_pay && (ser_empty || (ser_last_dibit && m_tready && !ser_last_byte));
  assign ser_load = s_tvalid && s_tready;
  assign ser_adv  = in_pay && hs;

  // Next preamble / header bit, selected by the decremented symbol index
  always_comb begin
    idx_dec   = sym_idx - 1'b1;
    pre_shift = PRE_PATTERN >> idx_dec;
    seq_shift = frame_seq >> idx_dec;
    pre_nxt   = pre_shift[0];
    seq_nxt   = seq_shift[0];
  end

  psk_dibit_ser u_ser (
    .clk_16M384 (clk_16M384),
    .rst_n      (rst_n),
    .load       (ser_load),
    .advance    (ser_adv),
    .byte_in    (s_tdata),
    .last_in    (s_tlast),
    .empty      (ser_empty),
    .last_dibit (ser_last_dibit),
    .last_byte  (ser_last_byte),
    .dibit      (ser_dibit)
  );

  // Frame sequencer: preamble and header counted down MSB..LSB, then payload
  always_ff @(posedge clk_16M384 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mv_q       <= 1'b0;
      mu_q       <= 1'b0;
      sym_q      <= '0;
      sym_idx    <= '0;
      frame_busy <= 1'b0;
      frame_seq  <= '0;
      underrun   <= 1'b0;
    end else begin
      underrun <= in_pay && ser_empty && m_tready;
      case (state)
        IDLE: begin
          if (s_tvalid) begin
            state      <= PRE;
            mv_q       <= 1'b1;
            mu_q       <= TUSER_BPSK;
            sym_q      <= bpsk_sym(PRE_PATTERN[PRE_LEN-1]);
            sym_idx    <= IDX_W'(PRE_LEN - 1);
            frame_busy <= 1'b1;
          end
        end
        PRE: begin
          if (hs) begin
            if (sym_idx == '0) begin
              state   <= SEQ;
              sym_q   <= bpsk_sym(frame_seq[SEQ_BITS-1]);
              sym_idx <= IDX_W'(SEQ_BITS - 1);
            end else begin
              sym_q   <= bpsk_sym(pre_nxt);
              sym_idx <= idx_dec;
            end
          end
        end
        SEQ: begin
          if (hs) begin
            if (sym_idx == '0) begin
              state <= PAY;
              mv_q  <= 1'b0;
              mu_q  <= TUSER_QPSK;
              sym_q <= '0;
            end else begin
              sym_q   <= bpsk_sym(seq_nxt);
              sym_idx <= idx_dec;
            end
          end
        end
        PAY: begin
          if (hs && m_tlast) begin
            state      <= IDLE;
            frame_busy <= 1'b0;
            frame_seq  <= frame_seq + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psk_framer.sv
// Directed bench for psk_framer with a periodic-tready modulator model.
module tb_psk_framer;
  timeunit 1ns;
  timeprecision 1ps;

  typedef struct {
    int unsigned pidx;
    logic [7:0]  data;
    logic        user;
    logic        last;
  } xfer_t;

  logic       clk_16M384 = 1'b0;
  logic       rstn_16M384 = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic       m_tlast;
  logic       m_tuser;
  logic       frame_busy;
  logic       underrun;
  logic [7:0] frame_seq;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          rdy_en = 1'b0;
  int unsigned per = 16;
  int unsigned ph = 0;
  int unsigned pcnt = 0;
  int unsigned tl_cnt = 0;
  int unsigned ur_cnt = 0;
  xfer_t       xq[$];
  logic [9:0]  exp_q[$];
  logic [12:0] pat = 13'b1111100110101;

  psk_framer #(
    .BYTES       (1),
    .PRE_LEN     (13),
    .PRE_PATTERN (13'b1111100110101),
    .SEQ_BITS    (8)
  ) dut (
    .clk_16M384  (clk_16M384),
    .rstn_16M384 (rstn_16M384),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .frame_busy  (frame_busy),
    .underrun    (underrun),
    .frame_seq   (frame_seq)
  );

  always #30 clk_16M384 = ~clk_16M384;

  // Modulator model: one-cycle tready every 'per' clocks, logs transfers and underruns
  always @(negedge clk_16M384) begin
    if (rdy_en && ph >= per - 1) begin
      m_tready = 1'b1;
      ph = 0;
      pcnt++;
    end else begin
      m_tready = 1'b0;
      if (rdy_en) ph++;
    end
    #1;
    if (m_tvalid && m_tready) begin
      xq.push_back(xfer_t'{pcnt, m_tdata, m_tuser, m_tlast});
      if (m_tlast) tl_cnt++;
    end
    if (underrun) ur_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic present(input logic [7:0] d, input logic l);
    @(negedge clk_16M384);
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = l;
  endtask

  task automatic wait_accept(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      #2;
      if (s_tready) ok = 1'b1;
      @(negedge clk_16M384);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_tl(input int unsigned target, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(posedge clk_16M384);
      #2;
      if (tl_cnt >= target) ok = 1'b1;
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_xfers(input int unsigned n, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(posedge clk_16M384);
      #2;
      if (xq.size() >= n) ok = 1'b1;
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  // Reference frame: {tuser, tlast, tdata}
  task automatic add_frame(input logic [7:0] seq, input logic [7:0] b0,
                           input logic [7:0] b1, input int unsigned nbytes);
    logic [7:0] bytes [2];
    logic [7:0] b;
    bytes[0] = b0;
    bytes[1] = b1;
    for (int i = 12; i >= 0; i--) exp_q.push_back({1'b1, 1'b0, pat[i] ? 8'h03 : 8'h00});
    for (int i = 7; i >= 0; i--)  exp_q.push_back({1'b1, 1'b0, seq[i] ? 8'h03 : 8'h00});
    for (int unsigned k = 0; k < nbytes; k++) begin
      b = bytes[k];
      for (int j = 3; j >= 0; j--) begin
        b = bytes[k] >> (2 * j);
        exp_q.push_back({1'b0, (k == nbytes - 1) && (j == 0), 6'b0, b[1:0]});
      end
    end
  endtask

  task automatic compare(input string tag);
    int unsigned n;
    chk({tag, "_len"}, 64'(xq.size()), 64'(exp_q.size()));
    n = (xq.size() < exp_q.size()) ? xq.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++)
      chk($sformatf("%s_sym%0d", tag, i), {xq[i].user, xq[i].last, xq[i].data}, exp_q[i]);
    xq.delete();
    exp_q.delete();
  endtask

  function automatic logic [7:0] header();
    logic [7:0] h = 'x;
    if (xq.size() >= 21)
      for (int i = 0; i < 8; i++) h[7-i] = xq[13+i].data[0];
    return h;
  endfunction

  initial begin
    int unsigned t;
    int unsigned exp_ur;
    int unsigned frame_cnt;
    int unsigned bad;
    logic [10:0] snap;

    // Reset state
    repeat (4) @(negedge clk_16M384);
    #2;
    chk("reset_outputs", {m_tvalid, m_tuser, m_tlast, m_tdata, s_tready, frame_busy, underrun, frame_seq}, '0);
    rstn_16M384 = 1'b1;
    repeat (4) @(negedge clk_16M384);
    rdy_en = 1'b1;

    // Single frame, byte 0xB4
    t = tl_cnt;
    add_frame(8'h00, 8'hB4, 8'h00, 1);
    present(8'hB4, 1'b1);
    wait_accept("t1_accept");
    chk("t1_busy", 64'(frame_busy), 64'd1);
    wait_tl(t + 1, "t1_end");
    chk("t1_count", 64'(xq.size()), 64'd25);
    compare("t1");
    repeat (2) @(negedge clk_16M384);
    #2;
    chk("t1_busy_clr", 64'(frame_busy), 64'd0);
    chk("t1_seq", 64'(frame_seq), 64'd1);

    // Handshake hold mid-preamble
    t = tl_cnt;
    add_frame(8'h01, 8'h3C, 8'h00, 1);
    present(8'h3C, 1'b1);
    wait_xfers(5, "hold_reach");
    #5 rdy_en = 1'b0;
    @(negedge clk_16M384);
    #2;
    snap = {m_tvalid, m_tuser, m_tlast, m_tdata};
    bad = 0;
    repeat (100) begin
      @(negedge clk_16M384);
      #2;
      if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== snap) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    chk("hold_valid", 64'(m_tvalid), 64'd1);
    chk("hold_noxfer", 64'(xq.size()), 64'd5);
    rdy_en = 1'b1;
    wait_accept("hold_accept");
    wait_tl(t + 1, "hold_end");
    compare("hold");

    // Starvation between two payload bytes
    chk("no_underrun_yet", 64'(ur_cnt), 64'd0);
    t = tl_cnt;
    add_frame(8'h02, 8'h5A, 8'h1E, 2);
    present(8'h5A, 1'b0);
    wait_accept("st_accept1");
    wait_xfers(25, "st_byte1");
    repeat (64) @(negedge clk_16M384);
    present(8'h1E, 1'b1);
    wait_accept("st_accept2");
    wait_tl(t + 1, "st_end");
    exp_ur = (xq.size() >= 26) ? (xq[25].pidx - xq[24].pidx - 1) : 0;
    chk("st_gap", 64'(exp_ur >= 3), 64'd1);
    chk("st_underruns", 64'(ur_cnt), 64'(exp_ur));
    chk("st_tlast_once", 64'(tl_cnt - t), 64'd1);
    compare("st");

    // Sequence wrap, fast tready cadence
    @(posedge clk_16M384);
    #5 per = 2; ph = 0;
    frame_cnt = 3;
    while (frame_cnt < 257) begin
      xq.delete();
      t = tl_cnt;
      present(frame_cnt[7:0], 1'b1);
      wait_accept("wrap_accept");
      wait_tl(t + 1, "wrap_end");
      if (frame_cnt == 255) chk("wrap_hdr255", 64'(header()), 64'hFF);
      if (frame_cnt == 256) chk("wrap_hdr256", 64'(header()), 64'h00);
      frame_cnt++;
    end
    xq.delete();
    chk("wrap_seq", 64'(frame_seq), 64'd1);
    @(posedge clk_16M384);
    #5 per = 16; ph = 0;

    // Back-to-back frames
    t = tl_cnt;
    add_frame(8'h01, 8'hC3, 8'h00, 1);
    add_frame(8'h02, 8'h96, 8'h00, 1);
    present(8'hC3, 1'b1);
    wait_accept("b2b_acceptA");
    present(8'h96, 1'b1);
    wait_accept("b2b_acceptB");
    wait_tl(t + 2, "b2b_end");
    chk("b2b_slot", 64'((xq.size() >= 26) && (xq[25].pidx == xq[24].pidx + 1)), 64'd1);
    compare("b2b");

    // Async reset mid-payload
    present(8'h77, 1'b1);
    wait_accept("rst_accept");
    wait_xfers(23, "rst_reach");
    @(posedge clk_16M384);
    #7 rstn_16M384 = 1'b0;
    #1;
    chk("rst_async_outputs", {m_tvalid, m_tuser, m_tlast, m_tdata, s_tready, frame_busy, underrun, frame_seq}, '0);
    @(negedge clk_16M384);
    rstn_16M384 = 1'b1;
    repeat (4) @(negedge clk_16M384);
    xq.delete();
    t = tl_cnt;
    add_frame(8'h00, 8'hE1, 8'h00, 1);
    present(8'hE1, 1'b1);
    wait_accept("post_rst_accept");
    wait_tl(t + 1, "post_rst_end");
    compare("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
